// File: rtl/pack_pkg.sv
// Shared framing constants and types for the packSend/packRecv byte stream.
package pack_pkg;

  localparam logic [7:0]  SYNC_FF   = 8'hFF;
  localparam logic [7:0]  SYNC_TAIL = 8'h7F;
  localparam int unsigned SYNC_LEN  = 4;
  localparam logic [SYNC_LEN*8-1:0] SYNC_WORD = {SYNC_FF, SYNC_FF, SYNC_FF, SYNC_TAIL};

  typedef enum logic {
    StHunt,
    StSynced
  } recv_state_e;

  function automatic logic isSync(input logic [SYNC_LEN*8-1:0] w);
    return w == SYNC_WORD;
  endfunction

endpackage

// File: rtl/pack_sync_detect.sv
// Byte shift window with sync-sequence compare; serves both lock hunting and boundary checks.
module pack_sync_detect
  import pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shiftEn,
  input  logic                    clear,
  input  logic [7:0]              byteIn,
  output logic [SYNC_LEN*8-1:0]   windowNext,
  output logic                    matchNext
);

  logic [SYNC_LEN*8-1:0] window;

  // Compare against the window as it will be once byteIn is shifted in, so the decision
  // is made in the same cycle the byte arrives.
  assign windowNext = {window[SYNC_LEN*8-9:0], byteIn};
  assign matchNext  = isSync(windowNext);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
    end else if (clear) begin
      window <= shiftEn ? {{(SYNC_LEN*8-8){1'b0}}, byteIn} : '0;
    end else if (shiftEn) begin
      window <= windowNext;
    end
  end

endmodule

// File: rtl/pack_recv.sv
// Receive side of the packed byte stream: sync hunt, frame counting, boundary-sync stripping
// and word re-presentation on the packet-processor interface.
module pack_recv
  import pack_pkg::*;
#(
  parameter int unsigned FRAME_WORDS  = 8,
  parameter int unsigned SYNC_TO_LOG2 = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  DataVal,
  input  logic        DataReady,
  output logic        DataNext,
  input  logic        Hold,
  output logic [15:0] PacketWd,
  output logic        WdAvail,
  output logic        PacketCommit,
  output logic        PacketReset,
  output logic        Synced,
  output logic        SyncSeen
);

  localparam int unsigned    CntW    = $clog2(2 * FRAME_WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * FRAME_WORDS - 1);
  localparam logic [CntW-1:0] HdrCnt  = CntW'(3);

  recv_state_e             stateQ;
  logic [CntW-1:0]         byteCnt;
  logic [7:0]              lowByte;
  logic [15:0]             word1Stage;
  logic                    word1Pend;
  logic                    commitArm;
  logic                    commitPend;
  logic                    frameEmitted;
  logic [SYNC_TO_LOG2-1:0] timer;

  logic [7:0]              byteIn;
  logic                    unusedHi;
  logic [SYNC_LEN*8-1:0]   windowNext;
  logic                    matchNext;
  logic                    timeout;
  logic                    cntHigh;
  logic                    emitReq;

  assign byteIn   = DataVal[7:0];
  assign unusedHi = ^DataVal[9:8];
  assign timeout  = (stateQ == StSynced) && (timer == '1);
  assign cntHigh  = 32'(byteCnt) >= 32'd4;
  assign Synced   = (stateQ == StSynced);

  // A new word emission requested by the byte arriving this cycle.
  assign emitReq = (stateQ == StSynced) && DataReady && !timeout &&
                   (((byteCnt == HdrCnt) && !matchNext) || (cntHigh && byteCnt[0]));

  pack_sync_detect u_sync (
    .clk        (clk),
    .rst        (rst),
    .shiftEn    (DataReady),
    .clear      (timeout),
    .byteIn     (byteIn),
    .windowNext (windowNext),
    .matchNext  (matchNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ       <= StHunt;
      byteCnt      <= '0;
      lowByte      <= '0;
      word1Stage   <= '0;
      word1Pend    <= 1'b0;
      commitArm    <= 1'b0;
      commitPend   <= 1'b0;
      frameEmitted <= 1'b0;
      timer        <= '0;
      DataNext     <= 1'b0;
      PacketWd     <= '0;
      WdAvail      <= 1'b0;
      PacketCommit <= 1'b0;
      PacketReset  <= 1'b0;
      SyncSeen     <= 1'b0;
    end else begin
      DataNext     <= !Hold;
      WdAvail      <= 1'b0;
      PacketCommit <= 1'b0;
      PacketReset  <= 1'b0;
      SyncSeen     <= 1'b0;

      // Second header word trails word 0 by one cycle.
      if (word1Pend && !timeout) begin
        PacketWd  <= word1Stage;
        WdAvail   <= 1'b1;
        word1Pend <= 1'b0;
        if (commitArm) begin
          commitPend <= 1'b1;
          commitArm  <= 1'b0;
        end
      end
      if (commitPend) begin
        PacketCommit <= 1'b1;
        commitPend   <= 1'b0;
      end

      unique case (stateQ)
        StHunt: begin
          if (DataReady && matchNext) begin
            stateQ       <= StSynced;
            byteCnt      <= '0;
            timer        <= '0;
            frameEmitted <= 1'b0;
            SyncSeen     <= 1'b1;
          end
        end

        StSynced: begin
          timer <= timer + 1'b1;
          if (timeout) begin
            // Byte arriving now is left to the cleared hunt window.
            stateQ       <= StHunt;
            PacketReset  <= frameEmitted;
            frameEmitted <= 1'b0;
            byteCnt      <= '0;
            lowByte      <= '0;
            word1Stage   <= '0;
            word1Pend    <= 1'b0;
            commitArm    <= 1'b0;
          end else if (DataReady) begin
            byteCnt <= (byteCnt == LastCnt) ? '0 : byteCnt + 1'b1;
            if (byteCnt == HdrCnt) begin
              if (matchNext) begin
                byteCnt  <= '0;
                timer    <= '0;
                SyncSeen <= 1'b1;
              end else begin
                PacketWd     <= {windowNext[23:16], windowNext[31:24]};
                WdAvail      <= 1'b1;
                word1Stage   <= {windowNext[7:0], windowNext[15:8]};
                word1Pend    <= 1'b1;
                frameEmitted <= (byteCnt != LastCnt);
                commitArm    <= (byteCnt == LastCnt);
              end
            end else if (cntHigh) begin
              if (!byteCnt[0]) begin
                lowByte <= byteIn;
              end else begin
                PacketWd     <= {byteIn, lowByte};
                WdAvail      <= 1'b1;
                frameEmitted <= (byteCnt != LastCnt);
                if (byteCnt == LastCnt) begin
                  commitPend <= 1'b1;
                end
              end
            end
          end
        end

        default: stateQ <= StHunt;
      endcase
    end
  end

  // Header word 1 must never collide with a freshly completed word.
  assert property (@(posedge clk) disable iff (!rst) !(word1Pend && emitReq));

endmodule
